// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data_memory arbiter: state encoding, requester ids and
// the data_memory geometry defaults.
package data_memory_arbiter_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_A = 2'd1,
        ARB_GNT_B = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of both requester ports plus the data_memory port seen by the arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface data_memory_arbiter_if
    import data_memory_arbiter_pkg::*;
#(
    parameter int AW = MEM_ADDR_W,
    parameter int DW = MEM_DATA_W
);
    logic          req_a;
    logic          we_a;
    logic          lock_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          gnt_a;
    logic          rvalid_a;

    logic          req_b;
    logic          we_b;
    logic          lock_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic          gnt_b;
    logic          rvalid_b;

    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_a, we_a, lock_a, addr_a, wdata_a,
        input  req_b, we_b, lock_b, addr_b, wdata_b,
        input  mem_rdata,
        output gnt_a, rvalid_a, gnt_b, rvalid_b, rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_a, we_a, lock_a, addr_a, wdata_a,
        output req_b, we_b, lock_b, addr_b, wdata_b,
        output mem_rdata,
        input  gnt_a, rvalid_a, gnt_b, rvalid_b, rdata,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to prio_i.
module rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    prio_i,
    output logic       valid_o,
    output req_id_t    pick_o
);

    // Bit 0 is requester A, bit 1 is requester B.
    always_comb begin
        valid_o = 1'b0;
        pick_o  = prio_i;
        case (req_i)
            2'b01: begin
                valid_o = 1'b1;
                pick_o  = REQ_A;
            end
            2'b10: begin
                valid_o = 1'b1;
                pick_o  = REQ_B;
            end
            2'b11: begin
                valid_o = 1'b1;
                pick_o  = prio_i;
            end
            default: begin
                valid_o = 1'b0;
                pick_o  = prio_i;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data_memory between the datapath (A) and the I/O loader (B):
// registered round-robin grant with optional bounded lock and a one-cycle read return.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input logic                      clk,
    input logic                      reset,
    data_memory_arbiter_if.slave     bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_e          state_q, state_d;
    req_id_t             prio_q, prio_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                rvalid_a_q, rvalid_a_d;
    logic                rvalid_b_q, rvalid_b_d;

    logic                beat_a_s, beat_b_s, hold_ok_s;
    req_id_t             eff_prio_s, pick_s;
    logic                pick_valid_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   addr_mux_s;
    logic [DATA_W-1:0]   wdata_mux_s;

    assign beat_a_s  = (state_q == ARB_GNT_A) && bus.req_a;
    assign beat_b_s  = (state_q == ARB_GNT_B) && bus.req_b;
    assign hold_ok_s = int'(hold_cnt_q) < (MAX_HOLD - 1);

    // Whoever held the grant this cycle yields a tie to the other side.
    always_comb begin
        case (state_q)
            ARB_GNT_A: eff_prio_s = other_req(REQ_A);
            ARB_GNT_B: eff_prio_s = other_req(REQ_B);
            default:   eff_prio_s = prio_q;
        endcase
    end

    rr_arbiter2 u_rr (
        .req_i   ({bus.req_b, bus.req_a}),
        .prio_i  (eff_prio_s),
        .valid_o (pick_valid_s),
        .pick_o  (pick_s)
    );

    // Next grant: extend a locked owner while under the hold limit, else re-arbitrate.
    always_comb begin
        state_d    = ARB_IDLE;
        prio_d     = prio_q;
        hold_cnt_d = hold_cnt_q;
        rvalid_a_d = beat_a_s && !bus.we_a;
        rvalid_b_d = beat_b_s && !bus.we_b;
        if (beat_a_s && bus.lock_a && hold_ok_s) begin
            state_d    = ARB_GNT_A;
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else if (beat_b_s && bus.lock_b && hold_ok_s) begin
            state_d    = ARB_GNT_B;
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
            if (pick_valid_s) begin
                state_d = (pick_s == REQ_A) ? ARB_GNT_A : ARB_GNT_B;
            end else begin
                state_d = ARB_IDLE;
            end
            if (state_q == ARB_GNT_A) begin
                prio_d     = REQ_B;
                hold_cnt_d = {HOLD_W{1'b0}};
            end else if (state_q == ARB_GNT_B) begin
                prio_d     = REQ_A;
                hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
                hold_cnt_d = {HOLD_W{1'b0}};
            end
        end
    end

    // Grant state, priority, hold counter and read-return pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            prio_q     <= REQ_A;
            hold_cnt_q <= {HOLD_W{1'b0}};
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    // Memory port mux; a withdrawn request leaves the port quiet.
    always_comb begin
        mem_we_s    = 1'b0;
        addr_mux_s  = {ADDR_W{1'b0}};
        wdata_mux_s = {DATA_W{1'b0}};
        case (state_q)
            ARB_GNT_A: begin
                if (bus.req_a) begin
                    mem_we_s    = bus.we_a;
                    addr_mux_s  = bus.addr_a;
                    wdata_mux_s = bus.wdata_a;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ARB_GNT_B: begin
                if (bus.req_b) begin
                    mem_we_s    = bus.we_b;
                    addr_mux_s  = bus.addr_b;
                    wdata_mux_s = bus.wdata_b;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: mem_we_s = 1'b0;
        endcase
    end

    // Reset masks every output so nothing reaches memory or a requester during it.
    assign bus.gnt_a     = !reset && (state_q == ARB_GNT_A);
    assign bus.gnt_b     = !reset && (state_q == ARB_GNT_B);
    assign bus.rvalid_a  = !reset && rvalid_a_q;
    assign bus.rvalid_b  = !reset && rvalid_b_q;
    assign bus.rdata     = (!reset && (rvalid_a_q || rvalid_b_q)) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.mem_we    = !reset && mem_we_s;
    assign bus.mem_addr  = reset ? {ADDR_W{1'b0}} : addr_mux_s;
    assign bus.mem_wdata = reset ? {DATA_W{1'b0}} : wdata_mux_s;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Cycle table plus hand-written sequence for data_memory_arbiter, with per-requester
// read-data scoreboards fed from a shadow copy of the memory.
module tb_data_memory_arbiter;

    typedef struct packed {
        logic       rst;
        logic       req_a, we_a, lock_a;
        logic [3:0] addr_a, wdata_a;
        logic       req_b, we_b, lock_b;
        logic [3:0] addr_b, wdata_b;
        logic       exp_ga, exp_gb;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_load;
    logic [3:0] mem [16];
    logic [3:0] exp_mem [16];
    logic [3:0] qa [$];
    logic [3:0] qb [$];
    logic exp_rva, exp_rvb;
    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [$];

    always #5 clk = ~clk;

    data_memory_arbiter_if bus ();

    data_memory_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read data_memory model.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 16; k++) mem[k] <= 4'(k + 7);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic vec_t mk(input logic rst,
                                input logic ra, input logic wa, input logic la,
                                input logic [3:0] aa, input logic [3:0] da,
                                input logic rb, input logic wb, input logic lb,
                                input logic [3:0] ab, input logic [3:0] db,
                                input logic ga, input logic gb);
        vec_t v;
        v.rst = rst; v.req_a = ra; v.we_a = wa; v.lock_a = la; v.addr_a = aa; v.wdata_a = da;
        v.req_b = rb; v.we_b = wb; v.lock_b = lb; v.addr_b = ab; v.wdata_b = db;
        v.exp_ga = ga; v.exp_gb = gb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t r);
        reset       = r.rst;
        bus.req_a   = r.req_a;  bus.we_a = r.we_a;  bus.lock_a = r.lock_a;
        bus.addr_a  = r.addr_a; bus.wdata_a = r.wdata_a;
        bus.req_b   = r.req_b;  bus.we_b = r.we_b;  bus.lock_b = r.lock_b;
        bus.addr_b  = r.addr_b; bus.wdata_b = r.wdata_b;
    endtask

    task automatic check_row(input vec_t r, input int idx);
        logic beat_a, beat_b, xwe;
        logic [3:0] xaddr, xdata, rd;
        check($sformatf("rvalid_a[%0d]", idx), bus.rvalid_a, exp_rva && !r.rst);
        if (bus.rvalid_a && qa.size() > 0) begin
            rd = qa.pop_front();
            check($sformatf("rdata_a[%0d]", idx), bus.rdata, rd);
        end
        check($sformatf("rvalid_b[%0d]", idx), bus.rvalid_b, exp_rvb && !r.rst);
        if (bus.rvalid_b && qb.size() > 0) begin
            rd = qb.pop_front();
            check($sformatf("rdata_b[%0d]", idx), bus.rdata, rd);
        end
        check($sformatf("gnt_a[%0d]", idx), bus.gnt_a, r.exp_ga);
        check($sformatf("gnt_b[%0d]", idx), bus.gnt_b, r.exp_gb);
        beat_a = r.exp_ga && r.req_a;
        beat_b = r.exp_gb && r.req_b;
        xwe    = beat_a ? r.we_a : (beat_b ? r.we_b : 1'b0);
        xaddr  = beat_a ? r.addr_a : r.addr_b;
        xdata  = beat_a ? r.wdata_a : r.wdata_b;
        check($sformatf("mem_we[%0d]", idx), bus.mem_we, xwe);
        if (beat_a || beat_b) begin
            check($sformatf("mem_addr[%0d]", idx), bus.mem_addr, xaddr);
            check($sformatf("mem_wdata[%0d]", idx), bus.mem_wdata, xdata);
        end
        if (r.rst) begin
            check($sformatf("rst_mem_addr[%0d]", idx), bus.mem_addr, 0);
            check($sformatf("rst_mem_wdata[%0d]", idx), bus.mem_wdata, 0);
            check($sformatf("rst_rdata[%0d]", idx), bus.rdata, 0);
        end
        exp_rva = beat_a && !r.we_a;
        exp_rvb = beat_b && !r.we_b;
        if (exp_rva) qa.push_back(exp_mem[r.addr_a]);
        if (exp_rvb) qb.push_back(exp_mem[r.addr_b]);
        if (xwe) exp_mem[xaddr] = xdata;
        if (r.rst) begin
            qa.delete(); qb.delete();
            exp_rva = 1'b0; exp_rvb = 1'b0;
        end
    endtask

    initial begin
        logic seen;
        logic [3:0] rd;
        for (int k = 0; k < 16; k++) exp_mem[k] = 4'(k + 7);
        exp_rva = 1'b0; exp_rvb = 1'b0;
        mem_load = 1'b1;
        drive(mk(1'b1, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));

        //          rst ra wa la aa    da     rb wb lb ab    db     ga gb
        vecs.push_back(mk(1, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        vecs.push_back(mk(1, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        // A reads addr 3 alone; re-granted once after its beat with req dropped
        vecs.push_back(mk(0, 1,0,0,4'h3,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        vecs.push_back(mk(0, 1,0,0,4'h3,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        // B writes 5 to addr 7, A then reads addr 7
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 1,1,0,4'h7,4'h5, 0,0));
        vecs.push_back(mk(0, 1,0,0,4'h7,4'h0, 1,1,0,4'h7,4'h5, 0,1));
        vecs.push_back(mk(0, 1,0,0,4'h7,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        // Reset, then both request continuously: strict alternation starting with A
        vecs.push_back(mk(1, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        vecs.push_back(mk(0, 1,0,0,4'h1,4'h0, 1,0,0,4'h2,4'h0, 0,0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 1,0,0,4'h1,4'h0, 1,0,0,4'h2,4'h0, (k % 2) == 0, (k % 2) == 1));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        // A locks: four A beats, one B beat, then A again
        vecs.push_back(mk(0, 1,0,1,4'h4,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 1,0,1,4'h4,4'h0, 1,0,0,4'h5,4'h0, k < 4, k == 4));
        vecs.push_back(mk(0, 1,0,0,4'h4,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        // A withdraws a pending write while granted; B then reads the untouched word
        vecs.push_back(mk(0, 1,1,0,4'h9,4'hF, 0,0,0,4'h0,4'h0, 0,0));
        vecs.push_back(mk(0, 0,1,0,4'h9,4'hF, 1,0,0,4'h9,4'h0, 1,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 1,0,0,4'h9,4'h0, 0,1));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,1));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        // Reset in the cycle after a read beat drops the pending rvalid
        vecs.push_back(mk(0, 1,0,0,4'h3,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        vecs.push_back(mk(0, 1,0,0,4'h3,4'h0, 0,0,0,4'h0,4'h0, 1,0));
        vecs.push_back(mk(1, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));
        vecs.push_back(mk(0, 0,0,0,4'h0,4'h0, 0,0,0,4'h0,4'h0, 0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            mem_load = (i == 0);
            @(negedge clk);
            check_row(vecs[i], i);
        end

        // B writes 6 to addr 12, then A reads it back; every wait is bounded.
        @(posedge clk); #1;
        bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 4'hC; bus.wdata_b = 4'h6;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = bus.gnt_b;
        end
        check("seq_gnt_b_seen", seen, 1);
        check("seq_b_mem_we", bus.mem_we, 1);
        check("seq_b_mem_addr", bus.mem_addr, 4'hC);
        exp_mem[12] = 4'h6;
        @(posedge clk); #1;
        bus.req_b = 1'b0; bus.we_b = 1'b0;
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'hC;
        qa.push_back(exp_mem[12]);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = bus.gnt_a;
        end
        check("seq_gnt_a_seen", seen, 1);
        check("seq_a_mem_we", bus.mem_we, 0);
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        @(negedge clk);
        check("seq_rvalid_a", bus.rvalid_a, 1);
        check("seq_rvalid_b", bus.rvalid_b, 0);
        if (qa.size() > 0) begin
            rd = qa.pop_front();
            check("seq_rdata_a", bus.rdata, rd);
        end
        check("sb_a_empty", qa.size(), 0);
        check("sb_b_empty", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
